// File: rtl/seven_seg_refresh_mux_pkg.sv
// Shared display package: digit count and widths used by the refresh mux
// and by the downstream seven-segment decoder.
package seven_seg_refresh_mux_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int SEL_W      = 2;

  // Frame boundary: the last digit slot of a frame.
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

  // One captured display image: codes plus decimal points.
  typedef struct packed {
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits;
    logic [NUM_DIGITS-1:0]              dots;
  } frame_t;
endpackage

// File: rtl/refresh_prescaler.sv
// refresh_prescaler: divides CLK into one TICK every CLK_DIV enabled cycles.
//   CLK    : system clock
//   RESET  : synchronous active-high reset (count -> 0)
//   ENABLE : 1 = count, 0 = hold count, no TICK
//   TICK   : high for the cycle in which count sits at CLK_DIV-1 with ENABLE=1
module refresh_prescaler #(
  parameter int CLK_DIV = 100000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ENABLE,
  output logic TICK
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  assign TICK = ENABLE && (count == TERM);

  always_ff @(posedge CLK) begin
    if (RESET)       count <= '0;
    else if (TICK)   count <= '0;
    else if (ENABLE) count <= count + 1'b1;
  end
endmodule

// File: rtl/seven_seg_refresh_mux.sv
// seven_seg_refresh_mux: time-multiplexed digit refresh with a double-buffered
// frame. LOAD writes a shadow frame; the shadow is copied to the displayed
// (active) frame only at the 3->0 slot boundary so a frame never mixes data.
//   CLK, RESET      : clock, synchronous active-high reset
//   ENABLE          : run/hold the refresh
//   LOAD            : strobe capturing DIGITS_IN/DOTS_IN into the shadow
//   DIGITS_IN[15:0] : digit n at [4n+3:4n]
//   DOTS_IN[3:0]    : dot n at bit n
//   BINARY[3:0]     : code of the selected digit
//   SEGMENT[1:0]    : selected digit index
//   DOT             : dot of the selected digit
//   PENDING         : shadow holds uncommitted data
//   UPDATED         : 1-cycle pulse after a commit
module seven_seg_refresh_mux
  import seven_seg_refresh_mux_pkg::*;
#(
  parameter int CLK_DIV = 100000
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            ENABLE,
  input  logic                            LOAD,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   DIGITS_IN,
  input  logic [NUM_DIGITS-1:0]           DOTS_IN,
  output logic [DIGIT_W-1:0]              BINARY,
  output logic [SEL_W-1:0]                SEGMENT,
  output logic                            DOT,
  output logic                            PENDING,
  output logic                            UPDATED
);
  logic   tick;
  logic   commit;
  frame_t shadow, active;
  logic [SEL_W-1:0] sel;

  refresh_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
    .CLK    (CLK),
    .RESET  (RESET),
    .ENABLE (ENABLE),
    .TICK   (tick)
  );

  assign commit = tick && (sel == LAST_SEL) && PENDING;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sel     <= '0;
      shadow  <= '0;
      active  <= '0;
      PENDING <= 1'b0;
      UPDATED <= 1'b0;
    end else begin
      UPDATED <= commit;
      if (tick) sel <= sel + 1'b1;
      // Commit reads the pre-LOAD shadow; a coinciding LOAD then re-arms
      // PENDING below, so its data lands one frame later.
      if (commit) begin
        active  <= shadow;
        PENDING <= 1'b0;
      end
      if (LOAD) begin
        shadow.digits <= DIGITS_IN;
        shadow.dots   <= DOTS_IN;
        PENDING       <= 1'b1;
      end
    end
  end

  assign SEGMENT = sel;
  assign BINARY  = active.digits[sel];
  assign DOT     = active.dots[sel];
endmodule

// File: tb/tb_seven_seg_refresh_mux.sv
module tb_seven_seg_refresh_mux;
  logic        CLK = 1'b0;
  logic        RESET, ENABLE, LOAD;
  logic [15:0] DIGITS_IN;
  logic [3:0]  DOTS_IN;
  logic [3:0]  BINARY;
  logic [1:0]  SEGMENT;
  logic        DOT, PENDING, UPDATED;

  int errors = 0;
  int checks = 0;
  int pulses;
  bit seen_a;

  seven_seg_refresh_mux #(.CLK_DIV(4)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .LOAD(LOAD),
    .DIGITS_IN(DIGITS_IN), .DOTS_IN(DOTS_IN), .BINARY(BINARY),
    .SEGMENT(SEGMENT), .DOT(DOT), .PENDING(PENDING), .UPDATED(UPDATED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock, then settle 1 time unit past the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Step n cycles, tallying UPDATED pulses and any 'A' digit on display.
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (UPDATED) pulses++;
      if (BINARY == 4'hA) seen_a = 1'b1;
    end
  endtask

  initial begin
    RESET = 1'b1; ENABLE = 1'b0; LOAD = 1'b0; DIGITS_IN = '0; DOTS_IN = '0;
    step(3);
    chk("rst_seg", 16'(SEGMENT), 0);
    chk("rst_bin", 16'(BINARY), 0);
    chk("rst_dot", 16'(DOT), 0);
    chk("rst_pend", 16'(PENDING), 0);
    chk("rst_upd", 16'(UPDATED), 0);

    // t counts enabled edges since release: SEGMENT = (t/4)%4.
    RESET = 1'b0; ENABLE = 1'b1;
    step(3);  chk("seg_t3", 16'(SEGMENT), 0);
    step(1);  chk("seg_t4", 16'(SEGMENT), 1);
    step(4);  chk("seg_t8", 16'(SEGMENT), 2);
    step(4);  chk("seg_t12", 16'(SEGMENT), 3);
    step(4);  chk("seg_t16", 16'(SEGMENT), 0);

    // Single load in slot 1.
    step(4);  // t=20
    LOAD = 1'b1; DIGITS_IN = 16'h4321; DOTS_IN = 4'b0100;
    step(1);  // t=21
    LOAD = 1'b0;
    chk("sl_pend", 16'(PENDING), 1);
    chk("sl_bin_old", 16'(BINARY), 0);
    step(10); // t=31
    chk("sl_seg3", 16'(SEGMENT), 3);
    chk("sl_bin_pre", 16'(BINARY), 0);
    chk("sl_upd_pre", 16'(UPDATED), 0);
    step(1);  // t=32 commit
    chk("sl_upd", 16'(UPDATED), 1);
    chk("sl_pend0", 16'(PENDING), 0);
    chk("sl_bin0", 16'(BINARY), 1);
    chk("sl_dot0", 16'(DOT), 0);
    step(1);  chk("sl_upd_off", 16'(UPDATED), 0);
    step(3);  chk("sl_bin1", 16'(BINARY), 2);
    step(4);  chk("sl_bin2", 16'(BINARY), 3);
    chk("sl_dot2", 16'(DOT), 1);
    step(4);  chk("sl_bin3", 16'(BINARY), 4);
    chk("sl_dot3", 16'(DOT), 0);
    step(4);  // t=48

    // Latest LOAD wins.
    pulses = 0; seen_a = 1'b0;
    LOAD = 1'b1; DIGITS_IN = 16'hAAAA; DOTS_IN = 4'b0000;
    step(1); LOAD = 1'b0;           // t=49
    step(3);                        // t=52
    LOAD = 1'b1; DIGITS_IN = 16'h5678;
    step(1); LOAD = 1'b0;           // t=53
    watch(11);                      // t=64 commit
    chk("lw_bin0", 16'(BINARY), 8);
    watch(4); chk("lw_bin1", 16'(BINARY), 7);
    watch(4); chk("lw_bin2", 16'(BINARY), 6);
    watch(4); chk("lw_bin3", 16'(BINARY), 5);   // t=76
    chk("lw_pulses", 16'(pulses), 1);
    chk("lw_no_a", 16'(seen_a), 0);

    // LOAD coinciding with the commit tick.
    LOAD = 1'b1; DIGITS_IN = 16'h1111; DOTS_IN = 4'b0000;
    step(1); LOAD = 1'b0;           // t=77
    step(2);                        // t=79
    LOAD = 1'b1; DIGITS_IN = 16'h2222;
    step(1); LOAD = 1'b0;           // t=80 commit of 1111
    chk("lc_upd", 16'(UPDATED), 1);
    chk("lc_pend", 16'(PENDING), 1);
    chk("lc_bin", 16'(BINARY), 1);
    step(4);  chk("lc_bin1", 16'(BINARY), 1);
    step(11); chk("lc_bin_pre", 16'(BINARY), 1);  // t=95
    chk("lc_upd_pre", 16'(UPDATED), 0);
    step(1);                                      // t=96
    chk("lc_upd2", 16'(UPDATED), 1);
    chk("lc_bin2", 16'(BINARY), 2);
    chk("lc_pend0", 16'(PENDING), 0);

    // ENABLE hold in slot 2 with prescaler at 1.
    step(9);                        // t=105
    ENABLE = 1'b0;
    step(10);
    chk("eh_seg", 16'(SEGMENT), 2);
    chk("eh_bin", 16'(BINARY), 2);
    ENABLE = 1'b1;
    step(2);  chk("eh_seg_rem", 16'(SEGMENT), 2);
    step(1);  chk("eh_seg_next", 16'(SEGMENT), 3);  // t=108

    // Reset with a pending load in slot 3.
    LOAD = 1'b1; DIGITS_IN = 16'h9999; DOTS_IN = 4'b1111;
    step(1); LOAD = 1'b0;
    chk("rm_pend", 16'(PENDING), 1);
    step(1);
    RESET = 1'b1;
    step(1);
    RESET = 1'b0;
    chk("rm_pend0", 16'(PENDING), 0);
    chk("rm_seg0", 16'(SEGMENT), 0);
    chk("rm_bin0", 16'(BINARY), 0);
    pulses = 0;
    watch(20);
    chk("rm_pulses", 16'(pulses), 0);
    chk("rm_bin_after", 16'(BINARY), 0);
    chk("rm_seg_after", 16'(SEGMENT), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
